// File: rtl/matmul_tick_ctrl_pkg.sv
// Shared definitions for the tick-stepped matrix-multiply controller:
// FSM state type, default geometry and the widths derived from it.
package matmul_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 8;

   // Index, address and accumulator widths for the default geometry.
   localparam int IDX_W  = $clog2(N_DEF);
   localparam int ADDR_W = 2 * IDX_W;
   localparam int ACC_W  = 2 * DW_DEF + IDX_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_FETCH = 3'd2,
      ST_MAC   = 3'd3,
      ST_WRITE = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/matmul_tick_ctrl_if.sv
// Memory-side bus of the matrix-multiply controller: synchronous-read
// ports for A and B, write port for C.
interface matmul_tick_ctrl_if
   import matmul_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
);

   localparam int AW = 2 * $clog2(N);
   localparam int CW = 2 * DW + $clog2(N);

   logic [AW-1:0] a_addr;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] a_data;
   logic [DW-1:0] b_data;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [CW-1:0] c_data;

   // Controller side drives addresses and the C write port.
   modport master (
      output a_addr, b_addr, c_we, c_addr, c_data,
      input  a_data, b_data
   );

   // Memory side returns read data and absorbs C writes.
   modport slave (
      input  a_addr, b_addr, c_we, c_addr, c_data,
      output a_data, b_data
   );

endinterface

// File: rtl/matmul_tick_ctrl_mac_acc.sv
// Dot-product accumulator: holds the running sum for one C element and
// exposes the sum-with-current-product so the final value can be
// captured on the same edge as the last accumulate.
module mm_mac_acc
   import matmul_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = ACC_W
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [CW-1:0] acc_sum
);

   logic [CW-1:0] acc_r;

   // Product is formed at full 2*DW width and zero-extended before the add.
   function automatic logic [CW-1:0] mac_step(
      input logic [CW-1:0] acc_in,
      input logic [DW-1:0] a_in,
      input logic [DW-1:0] b_in
   );
      logic [2*DW-1:0] prod;
      prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
      return acc_in + CW'(prod);
   endfunction

   assign acc_sum = mac_step(acc_r, a, b);

   // Accumulator register: clear wins over accumulate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_r <= '0;
      end else if (clr) begin
         acc_r <= '0;
      end else if (en) begin
         acc_r <= acc_sum;
      end
   end

endmodule

// File: rtl/matmul_tick_ctrl.sv
// Tick-stepped NxN matrix multiply controller. Each upstream tick advances
// one multiply-accumulate step; after N steps the finished C element is
// written, and after N*N elements a single done pulse is issued.
module matmul_tick_ctrl
   import matmul_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int DW = DW_DEF
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   output logic               busy,
   output logic               done,
   matmul_tick_ctrl_if.master mem
);

   localparam int IW = $clog2(N);
   localparam int AW = 2 * IW;
   localparam int CW = 2 * DW + IW;
   localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);

   state_t        state_r;
   state_t        state_s;
   logic [IW-1:0] i_r;
   logic [IW-1:0] j_r;
   logic [IW-1:0] k_r;
   logic          last_k_s;
   logic          last_elem_s;
   logic          acc_clr_s;
   logic          acc_en_s;
   logic [CW-1:0] acc_sum_s;
   logic [AW-1:0] a_addr_r;
   logic [AW-1:0] b_addr_r;
   logic          c_we_r;
   logic [AW-1:0] c_addr_r;
   logic [CW-1:0] c_data_r;
   logic          busy_r;
   logic          done_r;

   assign last_k_s    = (k_r == IDX_MAX);
   assign last_elem_s = (i_r == IDX_MAX) && (j_r == IDX_MAX);

   mm_mac_acc #(
      .DW (DW),
      .CW (CW)
   ) u_mac_acc (
      .clk     (clk),
      .rst     (rst),
      .clr     (acc_clr_s),
      .en      (acc_en_s),
      .a       (mem.a_data),
      .b       (mem.b_data),
      .acc_sum (acc_sum_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and accumulator control; ticks outside WAIT are dropped.
   always_comb begin
      state_s   = state_r;
      acc_clr_s = 1'b0;
      acc_en_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s   = ST_WAIT;
               acc_clr_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (tick) begin
               state_s = ST_FETCH;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_FETCH: begin
            state_s = ST_MAC;
         end
         ST_MAC: begin
            acc_en_s = 1'b1;
            if (last_k_s) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_WRITE: begin
            acc_clr_s = 1'b1;
            if (last_elem_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Index counters, read addresses and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_r      <= '0;
         j_r      <= '0;
         k_r      <= '0;
         a_addr_r <= '0;
         b_addr_r <= '0;
         c_we_r   <= 1'b0;
         c_addr_r <= '0;
         c_data_r <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         c_we_r <= 1'b0;
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  i_r    <= '0;
                  j_r    <= '0;
                  k_r    <= '0;
                  busy_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (tick) begin
                  // Row-major addressing: concatenation equals i*N+k and k*N+j.
                  a_addr_r <= {i_r, k_r};
                  b_addr_r <= {k_r, j_r};
               end
            end
            ST_MAC: begin
               if (last_k_s) begin
                  // Capture the finished element together with the last product.
                  c_we_r   <= 1'b1;
                  c_addr_r <= {i_r, j_r};
                  c_data_r <= acc_sum_s;
               end else begin
                  k_r <= k_r + IDX_ONE;
               end
            end
            ST_WRITE: begin
               k_r <= '0;
               if (j_r != IDX_MAX) begin
                  j_r <= j_r + IDX_ONE;
               end else begin
                  j_r <= '0;
                  i_r <= i_r + IDX_ONE;
               end
               if (last_elem_s) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign mem.a_addr = a_addr_r;
   assign mem.b_addr = b_addr_r;
   assign mem.c_we   = c_we_r;
   assign mem.c_addr = c_addr_r;
   assign mem.c_data = c_data_r;

endmodule

// File: doc/matmul_tick_ctrl.md
MATMUL_TICK_CTRL -- requirements
Module: matmul_tick_ctrl

Interface
REQ-001 Parameter: N, default 4, matrix dimension (square NxN, N a power of two, N >= 2).
REQ-002 Parameter: DW, default 8, unsigned element width of A and B.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: tick  in  1  one-cycle step pulse from the upstream pulse generator; consecutive pulses are at least 4 cycles apart.
REQ-006 Port: start  in  1  request to begin one full NxN multiply.
REQ-007 Port: busy  out  1  high from the cycle after start is accepted until done.
REQ-008 Port: done  out  1  one-cycle pulse after the last C element is written.
REQ-009 Port: a_addr, b_addr  out  2*log2(N) each  synchronous-read addresses of A (row-major) and B (row-major).
REQ-010 Port: a_data, b_data  in  DW each  read data, valid one cycle after address.
REQ-011 Port: c_we  out  1  write strobe for C memory, one cycle per element.
REQ-012 Port: c_addr  out  2*log2(N)  C address, row-major i*N+j.
REQ-013 Port: c_data  out  2*DW+log2(N)  dot-product result, unsigned, never overflows.

Function
REQ-014 FSM states IDLE, WAIT, FETCH, MAC, WRITE, DONE; encoding is free.
REQ-015 IDLE: start=1 -> WAIT; i, j, k and acc cleared to 0; busy=1 from the next cycle.
REQ-016 start is ignored in every state other than IDLE.
REQ-017 WAIT: tick=1 -> FETCH; a_addr and b_addr are registered to i*N+k and k*N+j on that edge.
REQ-018 FETCH: unconditional -> MAC (memory latency cycle).
REQ-019 MAC: acc <= acc + a_data*b_data. If k == N-1, go to WRITE; otherwise k increments and the FSM returns to WAIT.
REQ-020 WRITE: c_we=1, c_addr=i*N+j, c_data=acc for exactly one cycle; acc and k are then cleared.
REQ-021 WRITE index update: if j < N-1, j increments; otherwise j=0 and i increments. The next state is WAIT, except after i=N-1, j=N-1, where the next state is DONE.
REQ-022 DONE: done=1 for one cycle with busy=0 -> IDLE.
REQ-023 tick arriving in IDLE, FETCH, MAC, WRITE or DONE is discarded, never queued.
REQ-024 One tick is consumed per MAC; a full multiply consumes exactly N^3 ticks. Last tick -> done is 4 cycles.
REQ-025 c_we, c_addr and c_data are registered outputs. c_addr and c_data hold their last values when c_we=0.
REQ-026 The accumulator width is 2*DW+log2(N); the product is zero-extended before the add.

Reset
REQ-027 rst=0 forces, asynchronously, state=IDLE, i=j=k=0, acc=0, busy=0, done=0, c_we=0, a_addr=b_addr=c_addr=0, c_data=0.
REQ-028 Reset mid-operation aborts the multiply with no further C writes. After release, a new start is required.
REQ-029 After rst deasserts, the first rising edge behaves as IDLE.

Structure
REQ-030 Shared package matmul_pkg holds the FSM state typedef, defaults for N and DW, and the derived width constants (index, address, accumulator).
REQ-031 One sub-module, mm_mac_acc: accumulator register with clear and enable inputs and an accumulate-product function, reset by the same clk/rst.
REQ-032 Index counters and the FSM stay in matmul_tick_ctrl; no other hierarchy.

Verification
REQ-033 N=4, DW=8: A=identity, B[r][c]=4r+c, tick every 28 cycles, start pulse -> 16 writes with C=B in row-major order, then one done pulse, busy low afterwards.
REQ-034 All A and B elements 255 -> every c_data equals 260100 (0x3F804); no truncation.
REQ-035 Extra tick injected 1 cycle after a valid tick (in FETCH) -> ignored: k advances once, result unchanged versus the REQ-033 run.
REQ-036 start re-pulsed while busy, at write 5 -> no restart: write count stays 16, and the indices and data match REQ-033.
REQ-037 rst low for 1 cycle after the 7th C write -> all outputs 0 immediately, no further c_we, no done; a new start gives a correct complete run.
REQ-038 Ticks spaced at the 4-cycle minimum -> correct results, and done arrives 4 cycles after the 64th tick.
